// File: rtl/jtframe_inputs_pkg.sv
// Shared definitions for the player-input conditioner: stick bit layout,
// coin FSM and autofire phase encodings, and the stick rotation helper.
package jtframe_inputs_pkg;

  localparam int RIGHT = 0;
  localparam int LEFT  = 1;
  localparam int DOWN  = 2;
  localparam int UP    = 3;
  localparam int BTN0  = 4;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT} coin_st_t;
  typedef enum logic       {PRESS, RELEASE}         af_phase_t;

  // Remaps the four direction bits of one player for a cabinet turned 90 degrees.
  function automatic logic [3:0] rotate_dirs(input logic [3:0] d,
                                             input logic       en,
                                             input logic       ccw);
    logic [3:0] r;
    r = d;
    if (en) begin
      if (ccw) begin
        r[RIGHT] = d[DOWN];
        r[LEFT]  = d[UP];
        r[UP]    = d[RIGHT];
        r[DOWN]  = d[LEFT];
      end else begin
        r[RIGHT] = d[UP];
        r[LEFT]  = d[DOWN];
        r[DOWN]  = d[RIGHT];
        r[UP]    = d[LEFT];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jtframe_coin_pulse.sv
// One coin key shaper: a press edge gives a single low pulse of COIN_FRAMES
// frames, followed by a dead time, and waits for the key to be released.
module jtframe_coin_pulse
  import jtframe_inputs_pkg::*;
#(
  parameter int COIN_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic downloading,
  input  logic tick,
  input  logic coin_in,
  output logic coin_out
);

  localparam int             CW       = $clog2(COIN_FRAMES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(COIN_FRAMES - 1);

  coin_st_t       st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           prev_q;
  logic           press;

  assign press = ~coin_in & prev_q;

  // NOTE: reset is sampled on the clock edge; state registers use <= so every
  // flop in the design updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      prev_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      prev_q <= coin_in;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (downloading) begin
      st_d  = IDLE;
      cnt_d = '0;
    end else begin
      case (st_q)
        IDLE: if (press) begin
          st_d  = PULSE;
          cnt_d = '0;
        end
        PULSE, GAP: if (tick) begin
          if (cnt_q >= CNT_LAST) begin
            st_d  = (st_q == PULSE) ? GAP : WAIT;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT: if (coin_in) st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  assign coin_out = (st_q != PULSE);

endmodule

// File: rtl/jtframe_joy_cond.sv
// Player-input conditioner: registered sticks/starts with optional rotation and
// per-button autofire, shaped coin pulses, and all-idle outputs during download.
module jtframe_joy_cond
  import jtframe_inputs_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int BUTTONS     = 2,
  parameter int COIN_FRAMES = 3,
  parameter int AF_FRAMES   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           LVBL,
  input  logic                           downloading,
  input  logic                           rot_en,
  input  logic                           rot_ccw,
  input  logic [BUTTONS-1:0]             af_mask,
  input  logic [PLAYERS*(BUTTONS+4)-1:0] joy_in,
  input  logic [PLAYERS-1:0]             coin_in,
  input  logic [PLAYERS-1:0]             start_in,
  output logic [PLAYERS*(BUTTONS+4)-1:0] joy_out,
  output logic [PLAYERS-1:0]             coin_out,
  output logic [PLAYERS-1:0]             start_out
);

  localparam int            JOYW    = BUTTONS + 4;
  localparam int            AW      = $clog2(AF_FRAMES + 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AF_FRAMES - 1);

  logic               lvbl_q, tick_q;
  logic [PLAYERS-1:0] start_q;

  // lvbl_q resets low so a frame already in blank after reset is not a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvbl_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      lvbl_q <= LVBL;
      tick_q <= lvbl_q & ~LVBL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || downloading) start_q <= '1;
    else                    start_q <= start_in;
  end

  assign start_out = start_q;

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [3:0]         dir_in, dir_rot;
    logic [BUTTONS-1:0] btn_in, btn_d;
    logic               held;
    logic [AW-1:0]      af_cnt_q, af_cnt_d;
    af_phase_t          af_phase_q, af_phase_d;
    logic [JOYW-1:0]    joy_q;

    assign dir_in  = joy_in[p*JOYW +: 4];
    assign btn_in  = joy_in[p*JOYW+BTN0 +: BUTTONS];
    assign dir_rot = rotate_dirs(dir_in, rot_en, rot_ccw);
    assign held    = |(af_mask & ~btn_in);
    assign btn_d   = btn_in | (af_mask & {BUTTONS{af_phase_q == RELEASE}});

    always_comb begin
      af_cnt_d   = af_cnt_q;
      af_phase_d = af_phase_q;
      if (!held) begin
        af_cnt_d   = '0;
        af_phase_d = PRESS;
      end else if (tick_q) begin
        if (af_cnt_q >= AF_LAST) begin
          af_cnt_d   = '0;
          af_phase_d = (af_phase_q == PRESS) ? RELEASE : PRESS;
        end else begin
          af_cnt_d = af_cnt_q + AW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || downloading) begin
        joy_q      <= '1;
        af_cnt_q   <= '0;
        af_phase_q <= PRESS;
      end else begin
        joy_q      <= {btn_d, dir_rot};
        af_cnt_q   <= af_cnt_d;
        af_phase_q <= af_phase_d;
      end
    end

    assign joy_out[p*JOYW +: JOYW] = joy_q;

    jtframe_coin_pulse #(.COIN_FRAMES(COIN_FRAMES)) u_coin (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .tick        (tick_q),
      .coin_in     (coin_in[p]),
      .coin_out    (coin_out[p])
    );
  end

endmodule

// File: tb/tb_jtframe_joy_cond.sv
// Directed bench for jtframe_joy_cond (4 players, 6 buttons, 3-frame coin, 2-frame autofire)
// with a scoreboard of expected output vectors.
module tb_jtframe_joy_cond;

  localparam int P  = 4;
  localparam int B  = 6;
  localparam int JW = B + 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            LVBL = 1'b1;
  logic            downloading = 1'b0;
  logic            rot_en = 1'b0;
  logic            rot_ccw = 1'b0;
  logic [B-1:0]    af_mask = '0;
  logic [P*JW-1:0] joy_in = '1;
  logic [P-1:0]    coin_in = '1;
  logic [P-1:0]    start_in = '1;
  logic [P*JW-1:0] joy_out;
  logic [P-1:0]    coin_out;
  logic [P-1:0]    start_out;

  jtframe_joy_cond #(.PLAYERS(P), .BUTTONS(B), .COIN_FRAMES(3), .AF_FRAMES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .LVBL        (LVBL),
    .downloading (downloading),
    .rot_en      (rot_en),
    .rot_ccw     (rot_ccw),
    .af_mask     (af_mask),
    .joy_in      (joy_in),
    .coin_in     (coin_in),
    .start_in    (start_in),
    .joy_out     (joy_out),
    .coin_out    (coin_out),
    .start_out   (start_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [47:0] exp;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  localparam logic [P*JW-1:0] J1 = '1;

  function automatic logic [P*JW-1:0] put(input logic [P*JW-1:0] base, input int p,
                                          input logic [JW-1:0] v);
    logic [P*JW-1:0] r;
    r = base;
    r[p*JW +: JW] = v;
    return r;
  endfunction

  task automatic expect_out(input string tag, input logic [P*JW-1:0] j,
                            input logic [P-1:0] c, input logic [P-1:0] s);
    sb_t e;
    e.tag = tag;
    e.exp = {j, c, s};
    sb.push_back(e);
  endtask

  task automatic check_out();
    sb_t         e;
    logic [47:0] obs;
    obs = {joy_out, coin_out, start_out};
    e = sb.pop_front();
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One video frame: a single LVBL falling edge, then three idle cycles.
  task automatic frame();
    LVBL = 1'b0;
    step();
    LVBL = 1'b1;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset overrides pressed inputs, and the first cycle after it stays idle.
    joy_in = '0; coin_in = '0; start_in = '0;
    step(2);
    expect_out("reset_hold", J1, 4'hF, 4'hF);
    check_out();
    rst = 1'b0; joy_in = '1; coin_in = '1; start_in = '1;
    expect_out("post_reset", J1, 4'hF, 4'hF);
    step();
    check_out();

    // Plain registered path.
    joy_in = put(J1, 1, 10'b1111110110); start_in = 4'b1010;
    expect_out("passthru", put(J1, 1, 10'b1111110110), 4'hF, 4'b1010);
    step();
    check_out();
    start_in = '1;

    // Rotation: p0 up, p2 left, p3 right.
    rot_en = 1'b1; rot_ccw = 1'b0;
    joy_in = put(put(put(J1, 0, 10'b1111110111), 2, 10'b1111111101), 3, 10'b1111111110);
    expect_out("rot_cw",
               put(put(put(J1, 0, 10'b1111111110), 2, 10'b1111110111), 3, 10'b1111111011),
               4'hF, 4'hF);
    step();
    check_out();
    rot_ccw = 1'b1;
    expect_out("rot_ccw",
               put(put(put(J1, 0, 10'b1111111101), 2, 10'b1111111011), 3, 10'b1111110111),
               4'hF, 4'hF);
    step();
    check_out();
    rot_en = 1'b0; rot_ccw = 1'b0; joy_in = '1;
    step();

    // Coin 1 held for 10 frames: exactly three ticks low, then high.
    coin_in = 4'b1101;
    expect_out("coin1_start", J1, 4'b1101, 4'hF);
    step();
    check_out();
    for (int f = 1; f <= 10; f++) begin
      expect_out($sformatf("coin1_f%0d", f), J1, (f < 3) ? 4'b1101 : 4'b1111, 4'hF);
      frame();
      check_out();
    end
    coin_in = 4'b1111;
    expect_out("coin1_release", J1, 4'hF, 4'hF);
    step();
    check_out();
    coin_in = 4'b1101;
    expect_out("coin1_repress", J1, 4'b1101, 4'hF);
    step();
    check_out();
    repeat (6) frame();
    coin_in = 4'b1111;
    step();

    // Coin 0: a second press one frame later is absorbed into the first pulse.
    coin_in = 4'b1110;
    expect_out("coin0_start", J1, 4'b1110, 4'hF);
    step();
    check_out();
    coin_in = 4'b1111;
    step();
    frame();
    coin_in = 4'b1110;
    expect_out("coin0_second", J1, 4'b1110, 4'hF);
    step();
    check_out();
    frame();
    expect_out("coin0_end", J1, 4'b1111, 4'hF);
    frame();
    check_out();
    for (int f = 1; f <= 4; f++) begin
      expect_out($sformatf("coin0_held%0d", f), J1, 4'b1111, 4'hF);
      frame();
      check_out();
    end
    coin_in = 4'b1111;
    step();
    coin_in = 4'b1110;
    expect_out("coin0_new", J1, 4'b1110, 4'hF);
    step();
    check_out();
    repeat (6) frame();
    coin_in = 4'b1111;
    step();

    // Autofire on btn0 of every player; p0 holds btn0 and btn1.
    af_mask = 6'b000001;
    joy_in = put(J1, 0, 10'b1111001111);
    expect_out("af_start", put(J1, 0, 10'b1111001111), 4'hF, 4'hF);
    step();
    check_out();
    for (int k = 1; k <= 12; k++) begin
      logic b0;
      b0 = ((k / 2) % 2) != 0;
      expect_out($sformatf("af_%0d", k), put(J1, 0, {4'b1111, 1'b0, b0, 4'b1111}), 4'hF, 4'hF);
      frame();
      check_out();
    end
    joy_in = '1; af_mask = '0;
    step();

    // Download aborts a coin pulse and idles every output.
    coin_in = 4'b1011;
    expect_out("dl_coin_start", J1, 4'b1011, 4'hF);
    step();
    check_out();
    expect_out("dl_coin_f1", J1, 4'b1011, 4'hF);
    frame();
    check_out();
    downloading = 1'b1; joy_in = put(J1, 1, 10'b0000000000); start_in = '0;
    expect_out("dl_force", J1, 4'hF, 4'hF);
    step();
    check_out();
    coin_in = 4'b1111;
    step();
    downloading = 1'b0; joy_in = '1; start_in = '1;
    expect_out("dl_release", J1, 4'hF, 4'hF);
    step();
    check_out();
    coin_in = 4'b1011;
    expect_out("dl_fresh", J1, 4'b1011, 4'hF);
    step();
    check_out();
    for (int f = 1; f <= 3; f++) begin
      expect_out($sformatf("dl_fresh_f%0d", f), J1, (f < 3) ? 4'b1011 : 4'b1111, 4'hF);
      frame();
      check_out();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
